// File: rtl/perf_counter_bank_if.sv
// Control/readout bundle for perf_counter_bank: increment, clear, load and
// snapshot controls toward the bank, shadow readout and flags back.
interface perf_counter_bank_if #(
    parameter int DATA_BITS = 32,
    parameter int CHANNELS  = 4
);
    localparam int SEL_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]  inc;
    logic                 clr;
    logic                 load;
    logic [SEL_BITS-1:0]  load_sel;
    logic [DATA_BITS-1:0] load_data;
    logic                 snap;
    logic [SEL_BITS-1:0]  rd_sel;
    logic [DATA_BITS-1:0] rd_data;
    logic [CHANNELS-1:0]  ovf;
    logic                 snap_valid;

    modport master (
        output inc, clr, load, load_sel, load_data, snap, rd_sel,
        input  rd_data, ovf, snap_valid
    );

    modport slave (
        input  inc, clr, load, load_sel, load_data, snap, rd_sel,
        output rd_data, ovf, snap_valid
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of independent event counters with per-channel load, sticky overflow,
// and a snapshot/shadow path that is the only way to read counts out.
module perf_counter_bank #(
    parameter int DATA_BITS = 32,
    parameter int CHANNELS  = 4,
    parameter int SATURATE  = 0
) (
    input  logic clk,
    input  logic rst,
    perf_counter_bank_if.slave bus
);
    localparam int SEL_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [DATA_BITS-1:0] ALL_ONES = '1;

    logic [DATA_BITS-1:0] cnt    [CHANNELS];
    logic [DATA_BITS-1:0] shadow [CHANNELS];
    logic [CHANNELS-1:0]  ovf_q;
    logic                 snap_valid_q;
    logic [DATA_BITS-1:0] rd_mux;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
            ovf_q        <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // snap samples the pre-edge count, so it wins over a same-edge clr
                if (bus.snap)
                    shadow[i] <= cnt[i];
                else if (bus.clr)
                    shadow[i] <= '0;

                if (bus.clr) begin
                    cnt[i]   <= '0;
                    ovf_q[i] <= 1'b0;
                end else if (bus.load && (bus.load_sel == SEL_BITS'(i))) begin
                    cnt[i]   <= bus.load_data;
                    ovf_q[i] <= 1'b0;
                end else if (bus.inc[i]) begin
                    if (cnt[i] == ALL_ONES) begin
                        ovf_q[i] <= 1'b1;
                        if (SATURATE == 0)
                            cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + DATA_BITS'(1);
                    end
                end
            end

            if (bus.snap)
                snap_valid_q <= 1'b1;
            else if (bus.clr)
                snap_valid_q <= 1'b0;
        end
    end

    // Out-of-range selects fall through to zero rather than aliasing a channel.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.rd_sel == SEL_BITS'(i))
                rd_mux = shadow[i];
        end
    end

    assign bus.rd_data    = rd_mux;
    assign bus.ovf        = ovf_q;
    assign bus.snap_valid = snap_valid_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: three banks (8-bit wrap x4, 8-bit saturate x4, 8-bit wrap x3)
// share one stimulus stream and are checked against hand-computed values.
module tb_perf_counter_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] inc = '0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [1:0] load_sel = '0;
    logic [7:0] load_data = '0;
    logic       snap = 1'b0;
    logic [1:0] rd_sel = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    perf_counter_bank_if #(.DATA_BITS(8), .CHANNELS(4)) if_a ();
    perf_counter_bank_if #(.DATA_BITS(8), .CHANNELS(4)) if_b ();
    perf_counter_bank_if #(.DATA_BITS(8), .CHANNELS(3)) if_c ();

    assign if_a.inc = inc;       assign if_b.inc = inc;       assign if_c.inc = inc[2:0];
    assign if_a.clr = clr;       assign if_b.clr = clr;       assign if_c.clr = clr;
    assign if_a.load = load;     assign if_b.load = load;     assign if_c.load = load;
    assign if_a.load_sel = load_sel;   assign if_b.load_sel = load_sel;   assign if_c.load_sel = load_sel;
    assign if_a.load_data = load_data; assign if_b.load_data = load_data; assign if_c.load_data = load_data;
    assign if_a.snap = snap;     assign if_b.snap = snap;     assign if_c.snap = snap;
    assign if_a.rd_sel = rd_sel; assign if_b.rd_sel = rd_sel; assign if_c.rd_sel = rd_sel;

    perf_counter_bank #(.DATA_BITS(8), .CHANNELS(4), .SATURATE(0)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave));
    perf_counter_bank #(.DATA_BITS(8), .CHANNELS(4), .SATURATE(1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave));
    perf_counter_bank #(.DATA_BITS(8), .CHANNELS(3), .SATURATE(0)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_snap();
        snap = 1'b1;
        step();
        snap = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (if_a.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_a got %0h exp 0", if_a.rd_data); end
        n_checks++; if (if_a.ovf !== 4'b0000) begin n_fail++; $display("FAIL reset_ovf_a got %b exp 0000", if_a.ovf); end
        n_checks++; if (if_a.snap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_snapv_a got %b exp 0", if_a.snap_valid); end
        n_checks++; if (if_b.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_b got %0h exp 0", if_b.rd_data); end
        #10;
        rst = 1'b1;
    endtask

    task automatic test_basic_count();
        inc = 4'b0101;
        repeat (10) step();
        inc = 4'b0000;
        do_snap();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_v;
            exp_v = (i % 2 == 0) ? 8'd10 : 8'd0;
            rd_sel = 2'(i);
            #1;
            n_checks++; if (if_a.rd_data !== exp_v) begin n_fail++; $display("FAIL basic_rd_a[%0d] got %0d exp %0d", i, if_a.rd_data, exp_v); end
        end
        n_checks++; if (if_a.snap_valid !== 1'b1) begin n_fail++; $display("FAIL basic_snapv got %b exp 1", if_a.snap_valid); end
        rd_sel = 2'd2; #1;
        n_checks++; if (if_c.rd_data !== 8'd10) begin n_fail++; $display("FAIL basic_rd_c2 got %0d exp 10", if_c.rd_data); end
        rd_sel = 2'd3; #1;
        n_checks++; if (if_c.rd_data !== 8'd0) begin n_fail++; $display("FAIL c_rdsel3 got %0d exp 0", if_c.rd_data); end
    endtask

    task automatic test_snap_preedge();
        inc = 4'b0001;
        snap = 1'b1;
        step();
        inc = 4'b0000;
        snap = 1'b0;
        rd_sel = 2'd0; #1;
        n_checks++; if (if_a.rd_data !== 8'd10) begin n_fail++; $display("FAIL preedge_rd0 got %0d exp 10", if_a.rd_data); end
        do_snap();
        n_checks++; if (if_a.rd_data !== 8'd11) begin n_fail++; $display("FAIL preedge_rd0_after got %0d exp 11", if_a.rd_data); end
    endtask

    task automatic test_wrap_saturate();
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++; if (if_a.rd_data !== 8'd0) begin n_fail++; $display("FAIL clr_rd got %0d exp 0", if_a.rd_data); end
        n_checks++; if (if_a.snap_valid !== 1'b0) begin n_fail++; $display("FAIL clr_snapv got %b exp 0", if_a.snap_valid); end
        load = 1'b1; load_sel = 2'd1; load_data = 8'hFE;
        step();
        load = 1'b0;
        inc = 4'b0010;
        step();
        n_checks++; if (if_a.ovf !== 4'b0000) begin n_fail++; $display("FAIL wrap_ovf_early got %b exp 0000", if_a.ovf); end
        repeat (2) step();
        inc = 4'b0000;
        do_snap();
        rd_sel = 2'd1; #1;
        n_checks++; if (if_a.rd_data !== 8'h01) begin n_fail++; $display("FAIL wrap_rd_a got %0h exp 01", if_a.rd_data); end
        n_checks++; if (if_a.ovf !== 4'b0010) begin n_fail++; $display("FAIL wrap_ovf_a got %b exp 0010", if_a.ovf); end
        n_checks++; if (if_b.rd_data !== 8'hFF) begin n_fail++; $display("FAIL sat_rd_b got %0h exp ff", if_b.rd_data); end
        n_checks++; if (if_b.ovf !== 4'b0010) begin n_fail++; $display("FAIL sat_ovf_b got %b exp 0010", if_b.ovf); end
        n_checks++; if (if_c.rd_data !== 8'h01) begin n_fail++; $display("FAIL wrap_rd_c got %0h exp 01", if_c.rd_data); end
        n_checks++; if (if_c.ovf !== 3'b010) begin n_fail++; $display("FAIL wrap_ovf_c got %b exp 010", if_c.ovf); end
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_sel = 2'd2; load_data = 8'd100; inc = 4'b0100;
        step();
        load = 1'b0; inc = 4'b0000;
        do_snap();
        rd_sel = 2'd2; #1;
        n_checks++; if (if_a.rd_data !== 8'd100) begin n_fail++; $display("FAIL ldinc_rd_a got %0d exp 100", if_a.rd_data); end
        n_checks++; if (if_b.rd_data !== 8'd100) begin n_fail++; $display("FAIL ldinc_rd_b got %0d exp 100", if_b.rd_data); end
        n_checks++; if (if_a.ovf !== 4'b0010) begin n_fail++; $display("FAIL ldinc_ovf_a got %b exp 0010", if_a.ovf); end
        load = 1'b1; load_sel = 2'd1; load_data = 8'h10; inc = 4'b0010;
        step();
        load = 1'b0; inc = 4'b0000;
        n_checks++; if (if_a.ovf !== 4'b0000) begin n_fail++; $display("FAIL ld_clr_ovf_a got %b exp 0000", if_a.ovf); end
        n_checks++; if (if_b.ovf !== 4'b0000) begin n_fail++; $display("FAIL ld_clr_ovf_b got %b exp 0000", if_b.ovf); end
        load = 1'b1; load_sel = 2'd3; load_data = 8'h55;
        step();
        load = 1'b0;
        do_snap();
        rd_sel = 2'd3; #1;
        n_checks++; if (if_a.rd_data !== 8'h55) begin n_fail++; $display("FAIL ld3_rd_a got %0h exp 55", if_a.rd_data); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] exp_c;
            exp_c = (i == 0) ? 8'h00 : ((i == 1) ? 8'h10 : 8'd100);
            rd_sel = 2'(i);
            #1;
            n_checks++; if (if_c.rd_data !== exp_c) begin n_fail++; $display("FAIL ld_oob_rd_c[%0d] got %0h exp %0h", i, if_c.rd_data, exp_c); end
        end
        n_checks++; if (if_c.ovf !== 3'b000) begin n_fail++; $display("FAIL ld_oob_ovf_c got %b exp 000", if_c.ovf); end
    endtask

    task automatic test_snap_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        inc = 4'b1111;
        repeat (5) step();
        inc = 4'b0000;
        snap = 1'b1; clr = 1'b1;
        step();
        snap = 1'b0; clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            n_checks++; if (if_a.rd_data !== 8'd5) begin n_fail++; $display("FAIL snapclr_rd_a[%0d] got %0d exp 5", i, if_a.rd_data); end
        end
        n_checks++; if (if_a.snap_valid !== 1'b1) begin n_fail++; $display("FAIL snapclr_snapv got %b exp 1", if_a.snap_valid); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        rd_sel = 2'd0; #1;
        n_checks++; if (if_a.rd_data !== 8'd0) begin n_fail++; $display("FAIL clralone_rd got %0d exp 0", if_a.rd_data); end
        n_checks++; if (if_a.snap_valid !== 1'b0) begin n_fail++; $display("FAIL clralone_snapv got %b exp 0", if_a.snap_valid); end
        inc = 4'b0001;
        step();
        inc = 4'b0000;
        do_snap();
        n_checks++; if (if_a.rd_data !== 8'd1) begin n_fail++; $display("FAIL postclr_rd0 got %0d exp 1", if_a.rd_data); end
        rd_sel = 2'd1; #1;
        n_checks++; if (if_a.rd_data !== 8'd0) begin n_fail++; $display("FAIL postclr_rd1 got %0d exp 0", if_a.rd_data); end
        load = 1'b1; load_sel = 2'd3; load_data = 8'hFF;
        step();
        load = 1'b0; inc = 4'b1000;
        step();
        inc = 4'b0000;
        n_checks++; if (if_a.ovf !== 4'b1000) begin n_fail++; $display("FAIL ovf3_set got %b exp 1000", if_a.ovf); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++; if (if_a.ovf !== 4'b0000) begin n_fail++; $display("FAIL clr_ovf got %b exp 0000", if_a.ovf); end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_sel = 2'd0; load_data = 8'hFF;
        step();
        load = 1'b0; inc = 4'b0111;
        repeat (3) step();
        inc = 4'b0000;
        do_snap();
        rd_sel = 2'd1; #1;
        n_checks++; if (if_a.rd_data !== 8'd3) begin n_fail++; $display("FAIL prerst_rd1 got %0d exp 3", if_a.rd_data); end
        inc = 4'b0111;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (if_a.rd_data !== 8'd0) begin n_fail++; $display("FAIL arst_rd_a got %0d exp 0", if_a.rd_data); end
        n_checks++; if (if_a.ovf !== 4'b0000) begin n_fail++; $display("FAIL arst_ovf_a got %b exp 0000", if_a.ovf); end
        n_checks++; if (if_a.snap_valid !== 1'b0) begin n_fail++; $display("FAIL arst_snapv_a got %b exp 0", if_a.snap_valid); end
        n_checks++; if (if_c.rd_data !== 8'd0) begin n_fail++; $display("FAIL arst_rd_c got %0d exp 0", if_c.rd_data); end
        step();
        inc = 4'b0001;
        #2;
        rst = 1'b1;
        step();
        inc = 4'b0000;
        do_snap();
        rd_sel = 2'd0; #1;
        n_checks++; if (if_a.rd_data !== 8'd1) begin n_fail++; $display("FAIL relrst_rd0 got %0d exp 1", if_a.rd_data); end
        rd_sel = 2'd1; #1;
        n_checks++; if (if_a.rd_data !== 8'd0) begin n_fail++; $display("FAIL relrst_rd1 got %0d exp 0", if_a.rd_data); end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_snap_preedge();
        test_wrap_saturate();
        test_load_priority();
        test_snap_clr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 32, giving the width of each counter.
REQ-002 The block SHALL have parameter CHANNELS, default 4, giving the number of independent counters (range 1..16).
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 means counters wrap, 1 means counters hold at all-ones.
REQ-004 The block SHALL define SEL_BITS = max(1, ceil(log2(CHANNELS))).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port inc, input, CHANNELS bits: bit i requests an increment of counter i this cycle.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear of all counters and overflow flags.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 The block SHALL have port load_sel, input, SEL_BITS: the channel targeted by load.
REQ-011 The block SHALL have port load_data, input, DATA_BITS: the value written by load.
REQ-012 The block SHALL have port snap, input, 1 bit: copy all live counters into shadow registers.
REQ-013 The block SHALL have port rd_sel, input, SEL_BITS: selects the shadow register driven on rd_data.
REQ-014 The block SHALL have port rd_data, output, DATA_BITS: shadow[rd_sel], combinational.
REQ-015 The block SHALL have port ovf, output, CHANNELS bits: sticky overflow flag per channel, registered.
REQ-016 The block SHALL have port snap_valid, output, 1 bit: set once at least one snapshot has been taken since reset or clr, registered.

Function
REQ-017 Per channel, per rising edge, the block SHALL apply the following priority: clr, then load (only when load_sel == i), then inc[i], then hold.
REQ-018 An increment SHALL add exactly 1, modulo 2^DATA_BITS when SATURATE=0.
REQ-019 With SATURATE=1, an increment at all-ones SHALL leave the counter at all-ones.
REQ-020 ovf[i] SHALL be set on the edge where inc[i] is applied while counter i is all-ones, in either mode.
REQ-021 ovf[i] SHALL stay set until clr, or until a load to channel i, clears it.
REQ-022 A load to channel i in the same cycle as inc[i] SHALL write load_data, ignore the increment, and clear ovf[i].
REQ-023 load with load_sel >= CHANNELS SHALL have no effect on any counter or flag.
REQ-024 snap SHALL copy every counter's pre-edge value (the value before this edge's inc/load/clr) into its shadow register.
REQ-025 snap SHALL set snap_valid on the same edge.
REQ-026 snap and clr asserted together SHALL capture the pre-clear values and leave snap_valid = 1.
REQ-027 clr without snap SHALL zero the shadow registers and clear snap_valid.
REQ-028 rd_data SHALL equal shadow[rd_sel] with zero-cycle latency, and 0 when rd_sel >= CHANNELS.
REQ-029 Live counters SHALL never be directly observable; reads occur only through snapshots.
REQ-030 Channels SHALL be fully independent: simultaneous inc on all channels updates all of them in one cycle.

Reset
REQ-031 When rst is low, the block SHALL immediately, without waiting for clk, force all counters, shadows, ovf and snap_valid to 0, and rd_data to 0.
REQ-032 Deassertion of rst SHALL take effect at the next rising edge; inc asserted on that edge SHALL count.
REQ-033 Reset asserted mid-operation SHALL discard all counts and flags with no partial update.

Verification
REQ-034 Reset, inc=4'b0101 for 10 cycles, snap -> rd_sel 0..3 reads 10, 0, 10, 0; snap_valid=1.
REQ-035 SATURATE=0, DATA_BITS=8, load ch1=8'hFE, inc[1] for 3 cycles, snap -> rd_sel=1 reads 8'h01 and ovf=4'b0010; with SATURATE=1 it reads 8'hFF with ovf[1]=1.
REQ-036 load ch2=100 with inc[2]=1 in the same cycle, then snap -> rd_sel=2 reads 100 and ovf[2]=0.
REQ-037 Counters at 5, snap and clr in the same cycle -> shadows read 5, counters are 0, snap_valid=1; clr alone next cycle -> rd_data=0, snap_valid=0.
REQ-038 rst driven low between clock edges during counting -> all outputs are 0 before the next edge; CHANNELS=3 with rd_sel=3 -> rd_data=0.
